// File: rtl/noc_pkg.sv
// Shared NoC defaults and flit layout used by the switch-traversal crossbar.
package noc_pkg;

    localparam int NOC_D_WIDTH  = 32;
    localparam int NOC_VID_BITS = 6;
    localparam int NOC_PORTS    = 5;
    localparam int NOC_CHANNELS = 12;
    localparam int NOC_PAY_W    = NOC_D_WIDTH - NOC_VID_BITS;

    typedef struct packed {
        logic [NOC_VID_BITS-1:0] vid;
        logic [NOC_PAY_W-1:0]    payload;
    } flit_t;

endpackage

// File: rtl/xbar_out_arb.sv
// Per-output fixed-priority select: lowest-indexed requesting input wins.
module xbar_out_arb #(
    parameter int NUM_REQ = 60,
    parameter int IDX_W   = 6
) (
    input  logic [NUM_REQ-1:0] i_req,
    output logic               o_vld,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_multi
);

    logic [NUM_REQ-1:0] w_onehot;

    always_comb begin
        w_onehot = i_req & (~i_req + NUM_REQ'(1));
        o_vld    = |i_req;
        // Clearing the lowest set bit leaves something only if a second requester exists.
        o_multi  = |(i_req & (i_req - NUM_REQ'(1)));
        o_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                o_idx = o_idx | i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/xbar_st.sv
// Switch-traversal crossbar: routes granted input VC flits to output VCs with
// VID rewrite, fixed-priority collision resolution, stall hold and sticky errors.
module xbar_st
    import noc_pkg::*;
#(
    parameter int D_WIDTH  = NOC_D_WIDTH,
    parameter int VID_BITS = NOC_VID_BITS,
    parameter int PORTS    = NOC_PORTS,
    parameter int CHANNELS = NOC_CHANNELS,
    parameter int PIPE     = 1,
    localparam int NUM_REQ = PORTS * CHANNELS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                sa_gnt,
    input  logic [NUM_REQ-1:0][VID_BITS-1:0]  g_ovid,
    input  logic [NUM_REQ-1:0][D_WIDTH-1:0]   vc_inbuf_dout,
    input  logic                              st_stall,
    input  logic                              err_clr,
    output logic [NUM_REQ-1:0][D_WIDTH-1:0]   vc_outbuf_din,
    output logic [NUM_REQ-1:0]                vc_outbuf_wr,
    output logic                              collision_err,
    output logic [VID_BITS-1:0]               collision_vid,
    output logic                              range_err,
    output logic                              drop_err
);

    localparam int PAY_W = D_WIDTH - VID_BITS;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("xbar_st: PIPE must be 1 or 2");
    end

    logic [NUM_REQ-1:0][PAY_W-1:0]   w_pay;
    logic [NUM_REQ-1:0][NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0]              w_oor;
    logic [NUM_REQ-1:0]              w_sel_vld;
    logic [NUM_REQ-1:0]              w_multi;
    logic [NUM_REQ-1:0][IDX_W-1:0]   w_sel_idx;
    logic                            w_coll_any;
    logic [VID_BITS-1:0]             w_coll_vid;
    logic                            w_unused_vid;

    logic [NUM_REQ-1:0]              r_wr;
    logic [NUM_REQ-1:0][D_WIDTH-1:0] r_din;
    logic                            r_coll_err;
    logic [VID_BITS-1:0]             r_coll_vid;
    logic                            r_range_err;
    logic                            r_drop_err;

    // Request matrix is transposed: w_req[out][in]; stalled grants never request.
    always_comb begin
        w_pay        = '0;
        w_req        = '0;
        w_oor        = '0;
        w_unused_vid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pay[i]     = vc_inbuf_dout[i][PAY_W-1:0];
            w_unused_vid = w_unused_vid ^ (^vc_inbuf_dout[i][D_WIDTH-1:PAY_W]);
            if (sa_gnt[i] && !st_stall) begin
                if (32'(g_ovid[i]) >= 32'(NUM_REQ)) begin
                    w_oor[i] = 1'b1;
                end else begin
                    w_req[g_ovid[i]][i] = 1'b1;
                end
            end
        end
    end

    for (genvar o = 0; o < NUM_REQ; o++) begin : g_arb
        xbar_out_arb #(
            .NUM_REQ (NUM_REQ),
            .IDX_W   (IDX_W)
        ) u_arb (
            .i_req   (w_req[o]),
            .o_vld   (w_sel_vld[o]),
            .o_idx   (w_sel_idx[o]),
            .o_multi (w_multi[o])
        );
    end

    // Lowest colliding output id is reported when several collide together.
    always_comb begin
        w_coll_any = 1'b0;
        w_coll_vid = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            if (w_multi[o] && !w_coll_any) begin
                w_coll_any = 1'b1;
                w_coll_vid = o[VID_BITS-1:0];
            end
        end
    end

    if (PIPE == 2) begin : g_pipe2
        logic [NUM_REQ-1:0]            r_s1_vld;
        logic [NUM_REQ-1:0][IDX_W-1:0] r_s1_idx;
        logic [NUM_REQ-1:0][PAY_W-1:0] r_s1_pay;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_vld <= '0;
                r_s1_idx <= '0;
                r_s1_pay <= '0;
            end else if (!st_stall) begin
                r_s1_vld <= w_sel_vld;
                r_s1_idx <= w_sel_idx;
                r_s1_pay <= w_pay;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr  <= '0;
                r_din <= '0;
            end else if (!st_stall) begin
                for (int unsigned o = 0; o < NUM_REQ; o++) begin
                    r_wr[o]  <= r_s1_vld[o];
                    r_din[o] <= r_s1_vld[o] ? {o[VID_BITS-1:0], r_s1_pay[r_s1_idx[o]]} : '0;
                end
            end
        end
    end else begin : g_pipe1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr  <= '0;
                r_din <= '0;
            end else if (!st_stall) begin
                for (int unsigned o = 0; o < NUM_REQ; o++) begin
                    r_wr[o]  <= w_sel_vld[o];
                    r_din[o] <= w_sel_vld[o] ? {o[VID_BITS-1:0], w_pay[w_sel_idx[o]]} : '0;
                end
            end
        end
    end

    // A new error in the clear cycle wins; the vid latches only the first collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coll_err  <= 1'b0;
            r_coll_vid  <= '0;
            r_range_err <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_coll_err  <= (r_coll_err && !err_clr) || w_coll_any;
            r_range_err <= (r_range_err && !err_clr) || (|w_oor);
            r_drop_err  <= (r_drop_err && !err_clr) || (st_stall && (|sa_gnt));
            if (w_coll_any && (!r_coll_err || err_clr)) begin
                r_coll_vid <= w_coll_vid;
            end else if (err_clr) begin
                r_coll_vid <= '0;
            end
        end
    end

    assign vc_outbuf_wr  = r_wr & ~{NUM_REQ{st_stall}};
    assign vc_outbuf_din = r_din;
    assign collision_err = r_coll_err;
    assign collision_vid = r_coll_vid;
    assign range_err     = r_range_err;
    assign drop_err      = r_drop_err;

endmodule

// File: tb/tb_xbar_st.sv
// Randomized bench for xbar_st: PIPE=1 and PIPE=2 instances share stimulus and
// are compared every cycle against a transfer-level reference model.
module tb_xbar_st;
    import noc_pkg::*;

    localparam int NR = 60;
    localparam int DW = 32;
    localparam int VB = 6;
    localparam int PW = DW - VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, st_stall, err_clr;
    logic [NR-1:0]          sa_gnt;
    logic [NR-1:0][VB-1:0]  g_ovid;
    logic [NR-1:0][DW-1:0]  dout;
    logic [NR-1:0][DW-1:0]  din1, din2;
    logic [NR-1:0]          wr1, wr2;
    logic                   ce1, ce2, re1, re2, de1, de2;
    logic [VB-1:0]          cv1, cv2;

    xbar_st #(.PIPE(1)) u_dut1 (
        .clk(clk), .rst(rst), .sa_gnt(sa_gnt), .g_ovid(g_ovid), .vc_inbuf_dout(dout),
        .st_stall(st_stall), .err_clr(err_clr), .vc_outbuf_din(din1), .vc_outbuf_wr(wr1),
        .collision_err(ce1), .collision_vid(cv1), .range_err(re1), .drop_err(de1)
    );

    xbar_st #(.PIPE(2)) u_dut2 (
        .clk(clk), .rst(rst), .sa_gnt(sa_gnt), .g_ovid(g_ovid), .vc_inbuf_dout(dout),
        .st_stall(st_stall), .err_clr(err_clr), .vc_outbuf_din(din2), .vc_outbuf_wr(wr2),
        .collision_err(ce2), .collision_vid(cv2), .range_err(re2), .drop_err(de2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // m_vld/m_dat[dut][stage][output]; the last stage of dut p is stage p.
    bit            m_vld [2][2][NR];
    logic [DW-1:0] m_dat [2][2][NR];
    bit            m_ce, m_re, m_de;
    int            m_cv;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++)
                for (int o = 0; o < NR; o++) begin
                    m_vld[p][s][o] = 1'b0;
                    m_dat[p][s][o] = '0;
                end
        m_ce = 1'b0; m_re = 1'b0; m_de = 1'b0; m_cv = 0;
    endtask

    task automatic check_all();
        logic [NR-1:0] ew;
        for (int p = 0; p < 2; p++) begin
            for (int o = 0; o < NR; o++) ew[o] = m_vld[p][p][o] && !st_stall;
            check_eq($sformatf("wr_p%0d", p + 1), 64'(p == 1 ? wr2 : wr1), 64'(ew));
            for (int o = 0; o < NR; o++)
                check_eq($sformatf("din_p%0d[%0d]", p + 1, o),
                         64'(p == 1 ? din2[o] : din1[o]), 64'(m_dat[p][p][o]));
            check_eq($sformatf("coll_err_p%0d", p + 1), 64'(p == 1 ? ce2 : ce1), 64'(m_ce));
            check_eq($sformatf("coll_vid_p%0d", p + 1), 64'(p == 1 ? cv2 : cv1), 64'(m_cv));
            check_eq($sformatf("range_err_p%0d", p + 1), 64'(p == 1 ? re2 : re1), 64'(m_re));
            check_eq($sformatf("drop_err_p%0d", p + 1), 64'(p == 1 ? de2 : de1), 64'(m_de));
        end
    endtask

    // Transfer-level view: walk inputs in index order, first claimant of an output keeps it.
    task automatic model_edge();
        bit            nv [NR];
        logic [DW-1:0] nd [NR];
        bit            n_coll, n_range, n_drop;
        int            n_vid, v;
        n_coll = 1'b0; n_range = 1'b0; n_vid = 0;
        n_drop = st_stall && (sa_gnt != '0);
        for (int o = 0; o < NR; o++) begin nv[o] = 1'b0; nd[o] = '0; end
        if (!st_stall) begin
            for (int i = 0; i < NR; i++) begin
                if (sa_gnt[i]) begin
                    v = int'(g_ovid[i]);
                    if (v >= NR) n_range = 1'b1;
                    else if (nv[v]) begin
                        if (!n_coll || v < n_vid) n_vid = v;
                        n_coll = 1'b1;
                    end else begin
                        nv[v] = 1'b1;
                        nd[v] = DW'(v * (1 << PW)) + (dout[i] % DW'(1 << PW));
                    end
                end
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            if (!st_stall) begin
                for (int o = 0; o < NR; o++) begin
                    m_vld[1][1][o] = m_vld[1][0][o];
                    m_dat[1][1][o] = m_dat[1][0][o];
                    m_vld[1][0][o] = nv[o];
                    m_dat[1][0][o] = nd[o];
                    m_vld[0][0][o] = nv[o];
                    m_dat[0][0][o] = nd[o];
                end
            end
            if (n_coll && (!m_ce || err_clr)) m_cv = n_vid;
            else if (err_clr) m_cv = 0;
            m_ce = (m_ce && !err_clr) || n_coll;
            m_re = (m_re && !err_clr) || n_range;
            m_de = (m_de && !err_clr) || n_drop;
        end
    endtask

    task automatic tick();
        #2;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sa_gnt = '0; st_stall = 1'b0; err_clr = 1'b0; rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            g_ovid[i] = VB'($urandom_range(0, NR - 1));
            dout[i]   = $urandom;
        end
    endtask

    int            perm [NR];
    int            cnt, j, t;
    logic [DW-1:0] saved;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        check_eq("reset_wr1", 64'(wr1), 64'd0);
        check_eq("reset_din2_0", 64'(din2[0]), 64'd0);

        // Single grant: input 3 to output VC 7, all-ones data.
        idle();
        sa_gnt[3] = 1'b1; g_ovid[3] = VB'(7); dout[3] = 32'hFFFF_FFFF;
        tick();
        idle();
        #2;
        check_eq("single_din7", 64'(din1[7]), 64'h1FFF_FFFF);
        check_eq("single_wr", 64'(wr1), 64'(1) << 7);
        tick();

        // Inputs 2 and 5 collide on output 9; input 2 must win.
        idle();
        sa_gnt[2] = 1'b1; sa_gnt[5] = 1'b1; g_ovid[2] = VB'(9); g_ovid[5] = VB'(9);
        saved = dout[2];
        tick();
        idle();
        #2;
        check_eq("coll_din9", 64'(din1[9]), 64'({VB'(9), saved[PW-1:0]}));
        check_eq("coll_flag", 64'(ce1), 64'd1);
        check_eq("coll_vid", 64'(cv1), 64'd9);
        tick();
        err_clr = 1'b1;
        tick();
        idle();
        #2;
        check_eq("coll_clr_flag", 64'(ce1), 64'd0);
        check_eq("coll_clr_vid", 64'(cv1), 64'd0);
        tick();

        // Output id equal to NUM_REQ is out of range.
        idle();
        sa_gnt[0] = 1'b1; g_ovid[0] = VB'(60);
        tick();
        idle();
        #2;
        check_eq("range_no_wr", 64'(wr1), 64'd0);
        check_eq("range_flag", 64'(re1), 64'd1);
        tick();
        err_clr = 1'b1;
        tick();

        // Stall for three cycles right after a grant; a grant during stall is dropped.
        idle();
        sa_gnt[4] = 1'b1; g_ovid[4] = VB'(11);
        tick();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            st_stall = (k < 3);
            if (k == 1) begin sa_gnt[1] = 1'b1; g_ovid[1] = VB'(20); end
            #2;
            if (st_stall) check_eq("stall_wr2", 64'(wr2), 64'd0);
            cnt += int'(wr2[11]);
            tick();
        end
        check_eq("stall_emit_once", 64'(cnt), 64'd1);
        check_eq("stall_drop_flag", 64'(de2), 64'd1);

        // Full-throughput permutations, all inputs granted.
        for (int k = 0; k < 100; k++) begin
            idle();
            err_clr = (k == 0);
            for (int i = 0; i < NR; i++) perm[i] = i;
            for (int i = NR - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < NR; i++) g_ovid[i] = VB'(perm[i]);
            sa_gnt = '1;
            #1;
            if (k >= 1) check_eq("perm_count", 64'($countones(wr1)), 64'd60);
            tick();
        end

        // Mixed random traffic with collisions, out-of-range ids, stalls and clears.
        for (int k = 0; k < 150; k++) begin
            idle();
            for (int i = 0; i < NR; i++) begin
                sa_gnt[i] = ($urandom_range(0, 3) == 0);
                g_ovid[i] = VB'($urandom_range(0, (k % 2 == 1) ? 63 : 15));
            end
            st_stall = ($urandom_range(0, 7) == 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Reset with flits in flight; stall and clear asserted alongside must not matter.
        idle();
        sa_gnt = '1;
        for (int i = 0; i < NR; i++) g_ovid[i] = VB'(NR - 1 - i);
        tick();
        sa_gnt = '1; sa_gnt[0] = 1'b0;
        g_ovid[1] = VB'(3); g_ovid[2] = VB'(3); g_ovid[5] = VB'(62);
        rst = 1'b1; st_stall = 1'b1; err_clr = 1'b1;
        tick();
        idle();
        #2;
        check_eq("rst_wr1", 64'(wr1), 64'd0);
        check_eq("rst_wr2", 64'(wr2), 64'd0);
        check_eq("rst_flags", 64'({ce1, re1, de1, ce2, re2, de2}), 64'd0);
        tick();
        tick();
        check_eq("post_rst_wr2", 64'(wr2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_st.md
XBAR_ST -- requirements
Module: xbar_st

Interface
REQ-001 Parameters SHALL be: D_WIDTH 32, flit width; VID_BITS 6, VC id field width at flit MSBs; PORTS 5, router ports; CHANNELS 12, VCs per port; PIPE 1, register stages, legal 1 or 2; NUM_REQ = PORTS*CHANNELS (localparam).
REQ-002 Ports SHALL be: clk in 1, clock; rst in 1, reset.
REQ-003 sa_gnt in NUM_REQ, per-input switch-allocation grant.
REQ-004 g_ovid in NUM_REQ x VID_BITS, granted output VC id per input.
REQ-005 vc_inbuf_dout in NUM_REQ x D_WIDTH, input VC head flit.
REQ-006 st_stall in 1, freeze traversal pipeline.
REQ-007 err_clr in 1, clear sticky error flags.
REQ-008 vc_outbuf_din out NUM_REQ x D_WIDTH, flit to output VC buffer.
REQ-009 vc_outbuf_wr out NUM_REQ, write strobe per output VC.
REQ-010 collision_err out 1; collision_vid out VID_BITS; range_err out 1; drop_err out 1: sticky errors.
REQ-011 One clock, clk; reset rst SHALL be synchronous, active-high.

Function
REQ-012 Input i SHALL be routed to output g_ovid[i] when sa_gnt[i]=1, st_stall=0, g_ovid[i]<NUM_REQ and no lower-indexed input targets the same output.
REQ-013 Routed flit SHALL be {g_ovid[i], vc_inbuf_dout[i][D_WIDTH-VID_BITS-1:0]}: VID field replaced, payload unchanged.
REQ-014 Latency SHALL be exactly PIPE cycles from grant to vc_outbuf_wr/vc_outbuf_din, one flit per output per cycle, full throughput.
REQ-015 Outputs with no routed flit SHALL drive vc_outbuf_wr=0 and vc_outbuf_din=0.
REQ-016 Collision (two or more granted inputs, same in-range ovid, same cycle): lowest index wins, others dropped; collision_err set; collision_vid captures that ovid only on the first collision since the last clear.
REQ-017 g_ovid[i] >= NUM_REQ with sa_gnt[i]=1: flit dropped, range_err set.
REQ-018 st_stall=1: all pipeline registers hold; vc_outbuf_wr forced 0; vc_outbuf_din holds; any sa_gnt bit high that cycle is discarded and sets drop_err.
REQ-019 Stall release: held flits emitted on the first unstalled cycle, in order, none lost or duplicated.
REQ-020 err_clr=1 clears all error flags and collision_vid next cycle; a new error in the same cycle wins (flag set).
REQ-021 PIPE=2 SHALL register the decoded per-output select in stage 1 and the data in stage 2; PIPE=1 SHALL register outputs only.

Reset
REQ-022 rst=1 SHALL clear all pipeline valid bits, vc_outbuf_wr, vc_outbuf_din, all error flags and collision_vid to 0 on the next clk edge.
REQ-023 Reset mid-traversal SHALL discard in-flight flits; no write strobe in the cycle after reset deasserts.
REQ-024 rst SHALL override st_stall and err_clr.

Structure
REQ-025 D_WIDTH, VID_BITS, PORTS, CHANNELS defaults and the flit typedef (vid field + payload) SHALL live in shared package noc_pkg.
REQ-026 One sub-module xbar_out_arb (per-output lowest-index fixed-priority select, NUM_REQ instances) SHALL be used.
REQ-027 No latches; all state in one always_ff per stage.

Verification
REQ-028 Grant i=3 ovid=7, data 0xFFFF_FFFF, PIPE=1 -> next cycle wr[7]=1, din[7]=0x1FFF_FFFF (VID 7), all other wr 0.
REQ-029 Inputs 2 and 5 both to ovid 9 -> din[9] carries input 2 payload, collision_err=1, collision_vid=9; err_clr -> 0 next cycle.
REQ-030 ovid=60 with NUM_REQ=60 -> no wr asserted, range_err=1.
REQ-031 PIPE=2, flit granted, st_stall high 3 cycles starting next cycle -> wr 0 while stalled, flit emitted once on release; grant during stall -> drop_err=1.
REQ-032 All 60 inputs granted to a permutation each cycle for 100 cycles -> 60 writes/cycle, no errors, scoreboard match.
REQ-033 rst asserted with flits in flight -> no wr after reset, all outputs and flags 0.
